// File: rtl/mips_alu_pkg.sv
// Shared definitions for the mini-MIPS ALU: operation codes, datapath width and
// the first reserved operation code.
package mips_alu_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [4:0] {
        OP_ADD   = 5'd0,
        OP_ADDU  = 5'd1,
        OP_SUB   = 5'd2,
        OP_SUBU  = 5'd3,
        OP_AND   = 5'd4,
        OP_OR    = 5'd5,
        OP_XOR   = 5'd6,
        OP_NOR   = 5'd7,
        OP_SLL   = 5'd8,
        OP_SRL   = 5'd9,
        OP_SRA   = 5'd10,
        OP_SLT   = 5'd11,
        OP_SLTU  = 5'd12,
        OP_MUL   = 5'd13,
        OP_MULU  = 5'd14,
        OP_MADD  = 5'd15,
        OP_MADDU = 5'd16,
        OP_LUI   = 5'd17,
        OP_PASSA = 5'd18
    } alu_op_e;

    localparam logic [4:0] RESERVED_BASE = 5'd19;

endpackage

// File: rtl/mips_alu_mul.sv
// Combinational 32x32->64 multiplier; is_signed selects two's-complement or
// unsigned interpretation of both operands.
module mips_alu_mul
    import mips_alu_pkg::*;
(
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               is_signed,
    output logic [2*WIDTH-1:0] product
);

    logic signed [WIDTH:0]       ext_a;
    logic signed [WIDTH:0]       ext_b;
    logic signed [2*WIDTH+1:0]   full;

    // One extra bit lets a single signed multiplier serve both modes.
    assign ext_a   = {is_signed & a[WIDTH-1], a};
    assign ext_b   = {is_signed & b[WIDTH-1], b};
    assign full    = ext_a * ext_b;
    assign product = full[2*WIDTH-1:0];

endmodule

// File: rtl/mips_alu_core.sv
// Registered 32-bit ALU with one-cycle latency. Define ALU_MULDIV_EN to enable
// the multiply / multiply-accumulate ops and the HI/LO accumulator.
module mips_alu_core
    import mips_alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [4:0]       alu_ctrl,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             overflow
);

    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] res_next;
    logic             ovf_next;

    assign sum   = in_a + in_b;
    assign diff  = in_a - in_b;
    assign shamt = in_b[4:0];

`ifdef ALU_MULDIV_EN
    logic [2*WIDTH-1:0] acc_reg;
    logic [2*WIDTH-1:0] acc_next;
    logic               acc_we;
    logic [2*WIDTH-1:0] product;
    logic               mul_signed;
    logic [WIDTH-1:0]   hi_next;
    logic [WIDTH-1:0]   result_hi_reg;

    assign mul_signed = (alu_ctrl == OP_MUL) || (alu_ctrl == OP_MADD);

    mips_alu_mul u_mul (
        .a         (in_a),
        .b         (in_b),
        .is_signed (mul_signed),
        .product   (product)
    );
`endif

    always_comb begin
        res_next = '0;
        ovf_next = 1'b0;
`ifdef ALU_MULDIV_EN
        acc_next = acc_reg;
        acc_we   = 1'b0;
        hi_next  = '0;
`endif
        case (alu_ctrl)
            OP_ADD: begin
                res_next = sum;
                ovf_next = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_ADDU:  res_next = sum;
            OP_SUB: begin
                res_next = diff;
                ovf_next = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (diff[WIDTH-1] != in_a[WIDTH-1]);
            end
            OP_SUBU:  res_next = diff;
            OP_AND:   res_next = in_a & in_b;
            OP_OR:    res_next = in_a | in_b;
            OP_XOR:   res_next = in_a ^ in_b;
            OP_NOR:   res_next = ~(in_a | in_b);
            OP_SLL:   res_next = in_a << shamt;
            OP_SRL:   res_next = in_a >> shamt;
            OP_SRA:   res_next = $unsigned($signed(in_a) >>> shamt);
            OP_SLT:   res_next = {{(WIDTH-1){1'b0}}, $signed(in_a) < $signed(in_b)};
            OP_SLTU:  res_next = {{(WIDTH-1){1'b0}}, in_a < in_b};
`ifdef ALU_MULDIV_EN
            OP_MUL, OP_MULU: begin
                acc_we   = 1'b1;
                acc_next = product;
                res_next = acc_next[WIDTH-1:0];
                hi_next  = acc_next[2*WIDTH-1:WIDTH];
            end
            OP_MADD, OP_MADDU: begin
                acc_we   = 1'b1;
                acc_next = acc_reg + product;
                res_next = acc_next[WIDTH-1:0];
                hi_next  = acc_next[2*WIDTH-1:WIDTH];
            end
`endif
            OP_LUI:   res_next = {in_b[15:0], 16'h0000};
            OP_PASSA: res_next = in_a;
            default:  res_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                result   <= res_next;
                zero     <= (res_next == '0);
                overflow <= ovf_next;
            end
        end
    end

`ifdef ALU_MULDIV_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_reg       <= '0;
            result_hi_reg <= '0;
        end else if (in_valid) begin
            result_hi_reg <= hi_next;
            if (acc_we) begin
                acc_reg <= acc_next;
            end
        end
    end

    assign result_hi = result_hi_reg;
`else
    assign result_hi = '0;
`endif

endmodule

// File: tb/tb_mips_alu_core.sv
// Directed-vector bench for mips_alu_core; multiply expectations follow ALU_MULDIV_EN.
module tb_mips_alu_core;

`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic [4:0]  alu_ctrl = '0;
    logic [31:0] in_a = '0;
    logic [31:0] in_b = '0;
    logic        out_valid;
    logic [31:0] result;
    logic [31:0] result_hi;
    logic        zero;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    mips_alu_core dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .alu_ctrl  (alu_ctrl),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .result    (result),
        .result_hi (result_hi),
        .zero      (zero),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Drive one op on a negedge and return on the next negedge with in_valid low.
    task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        in_valid = 1'b1; alu_ctrl = op; in_a = a; in_b = b;
        @(negedge clk);
        in_valid = 1'b0;
        $display("op=%0d a=%h b=%h -> v=%b res=%h hi=%h z=%b ovf=%b", op, a, b, out_valid, result, result_hi, zero, overflow);
    endtask

    task automatic test_reset();
        logic [31:0] exp_res;
        @(negedge clk); @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL rst_result: got %h want 0", result); end
        total++; if (zero !== 1'b0) begin bad++; $display("FAIL rst_zero: got %b want 0", zero); end
        rst = 1'b1;
        issue(5'd1, 32'd1, 32'd2);
        total++; if (result !== 32'd3 || out_valid !== 1'b1) begin bad++; $display("FAIL addu_pre: got %h/%b want 3/1", result, out_valid); end
        issue(5'd14, 32'd5, 32'd7);
        // assert reset mid-cycle while a result is still valid
        @(negedge clk);
        in_valid = 1'b1; alu_ctrl = 5'd18; in_a = 32'h1234_5678; in_b = '0;
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (result !== 32'h1234_5678) begin bad++; $display("FAIL passa: got %h want 12345678", result); end
        #2 rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || result !== 32'h0 || result_hi !== 32'h0 || zero !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL async_rst: got v=%b r=%h hi=%h z=%b o=%b want all 0", out_valid, result, result_hi, zero, overflow);
        end
        @(negedge clk);
        rst = 1'b1;
        issue(5'd16, 32'd2, 32'd3);
        exp_res = MD ? 32'd6 : 32'd0;
        total++; if (result !== exp_res || result_hi !== 32'h0) begin bad++; $display("FAIL maddu_after_rst: got %h/%h want %h/0", result, result_hi, exp_res); end
        total++; if (zero !== !MD) begin bad++; $display("FAIL maddu_zero: got %b want %b", zero, !MD); end
    endtask

    task automatic test_arith();
        issue(5'd0, 32'h7FFF_FFFF, 32'h1);
        total++; if (result !== 32'h8000_0000 || overflow !== 1'b1 || zero !== 1'b0) begin bad++; $display("FAIL add_ovf: got %h o=%b z=%b want 80000000 o=1 z=0", result, overflow, zero); end
        issue(5'd1, 32'h7FFF_FFFF, 32'h1);
        total++; if (result !== 32'h8000_0000 || overflow !== 1'b0) begin bad++; $display("FAIL addu: got %h o=%b want 80000000 o=0", result, overflow); end
        issue(5'd2, 32'd5, 32'd5);
        total++; if (result !== 32'h0 || zero !== 1'b1 || overflow !== 1'b0) begin bad++; $display("FAIL sub_zero: got %h z=%b o=%b want 0 z=1 o=0", result, zero, overflow); end
        issue(5'd2, 32'h8000_0000, 32'h1);
        total++; if (result !== 32'h7FFF_FFFF || overflow !== 1'b1) begin bad++; $display("FAIL sub_ovf: got %h o=%b want 7fffffff o=1", result, overflow); end
        issue(5'd3, 32'h8000_0000, 32'h1);
        total++; if (result !== 32'h7FFF_FFFF || overflow !== 1'b0) begin bad++; $display("FAIL subu: got %h o=%b want 7fffffff o=0", result, overflow); end
        issue(5'd7, 32'hF0F0_0000, 32'h0000_00FF);
        total++; if (result !== 32'h0F0F_FF00) begin bad++; $display("FAIL nor: got %h want 0f0fff00", result); end
    endtask

    task automatic test_shift_cmp();
        issue(5'd10, 32'h8000_0000, 32'h24);
        total++; if (result !== 32'hF800_0000) begin bad++; $display("FAIL sra: got %h want f8000000", result); end
        issue(5'd9, 32'h8000_0000, 32'h24);
        total++; if (result !== 32'h0800_0000) begin bad++; $display("FAIL srl: got %h want 08000000", result); end
        issue(5'd8, 32'h0000_0003, 32'hFFFF_FFE1);
        total++; if (result !== 32'h0000_0006) begin bad++; $display("FAIL sll: got %h want 00000006", result); end
        issue(5'd11, 32'hFFFF_FFFF, 32'h1);
        total++; if (result !== 32'h1 || zero !== 1'b0) begin bad++; $display("FAIL slt: got %h z=%b want 1 z=0", result, zero); end
        issue(5'd12, 32'hFFFF_FFFF, 32'h1);
        total++; if (result !== 32'h0 || zero !== 1'b1) begin bad++; $display("FAIL sltu: got %h z=%b want 0 z=1", result, zero); end
        issue(5'd17, 32'h0, 32'hABCD_1234);
        total++; if (result !== 32'h1234_0000) begin bad++; $display("FAIL lui: got %h want 12340000", result); end
    endtask

    task automatic test_multiply();
        issue(5'd13, 32'hFFFF_FFFE, 32'd3);
        total++; if (result !== (MD ? 32'hFFFF_FFFA : 32'h0) || result_hi !== (MD ? 32'hFFFF_FFFF : 32'h0)) begin
            bad++; $display("FAIL mul: got %h/%h want %h/%h", result_hi, result, MD ? 32'hFFFF_FFFF : 32'h0, MD ? 32'hFFFF_FFFA : 32'h0);
        end
        issue(5'd15, 32'h0001_0000, 32'h0001_0000);
        total++; if (result !== (MD ? 32'hFFFF_FFFA : 32'h0) || result_hi !== 32'h0) begin
            bad++; $display("FAIL madd: got %h/%h want 0/%h", result_hi, result, MD ? 32'hFFFF_FFFA : 32'h0);
        end
        issue(5'd14, 32'hFFFF_FFFF, 32'd2);
        total++; if (result !== (MD ? 32'hFFFF_FFFE : 32'h0) || result_hi !== (MD ? 32'h1 : 32'h0)) begin
            bad++; $display("FAIL mulu: got %h/%h want %h/%h", result_hi, result, MD ? 32'h1 : 32'h0, MD ? 32'hFFFF_FFFE : 32'h0);
        end
        issue(5'd0, 32'd1, 32'd1);
        total++; if (result_hi !== 32'h0) begin bad++; $display("FAIL hi_clear: got %h want 0", result_hi); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        in_valid = 1'b1; alu_ctrl = 5'd1; in_a = 32'd10; in_b = 32'd20;
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || result !== 32'd30) begin bad++; $display("FAIL b2b_first: got %b/%h want 1/1e", out_valid, result); end
        alu_ctrl = 5'd6; in_a = 32'hFF00_FF00; in_b = 32'h0FF0_0FF0;
        @(negedge clk);
        total++; if (out_valid !== 1'b1 || result !== 32'hF0F0_F0F0) begin bad++; $display("FAIL b2b_second: got %b/%h want 1/f0f0f0f0", out_valid, result); end
        in_valid = 1'b0; alu_ctrl = 5'd1; in_a = 32'd1; in_b = 32'd1;
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || result !== 32'hF0F0_F0F0) begin bad++; $display("FAIL gap_hold: got %b/%h want 0/f0f0f0f0", out_valid, result); end
        @(negedge clk);
        total++; if (out_valid !== 1'b0 || result !== 32'hF0F0_F0F0) begin bad++; $display("FAIL gap_hold2: got %b/%h want 0/f0f0f0f0", out_valid, result); end
        issue(5'd4, 32'hFFFF_0000, 32'h00FF_FF00);
        total++; if (out_valid !== 1'b1 || result !== 32'h00FF_0000) begin bad++; $display("FAIL after_gap: got %b/%h want 1/00ff0000", out_valid, result); end
        $display("back_to_back sequence done");
    endtask

    task automatic test_reserved();
        issue(5'd14, 32'd3, 32'd4);
        issue(5'd25, 32'h1234_5678, 32'h8765_4321);
        total++; if (result !== 32'h0 || result_hi !== 32'h0 || zero !== 1'b1 || overflow !== 1'b0) begin
            bad++; $display("FAIL reserved: got %h/%h z=%b o=%b want 0/0 z=1 o=0", result_hi, result, zero, overflow);
        end
        issue(5'd15, 32'd1, 32'd1);
        total++; if (result !== (MD ? 32'd13 : 32'd0) || result_hi !== 32'h0) begin
            bad++; $display("FAIL acc_kept: got %h/%h want 0/%h", result_hi, result, MD ? 32'd13 : 32'd0);
        end
        issue(5'd15, 32'd2, 32'd2);
        total++; if (result !== (MD ? 32'd17 : 32'd0)) begin bad++; $display("FAIL madd_chain: got %h want %h", result, MD ? 32'd17 : 32'd0); end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_shift_cmp();
        test_multiply();
        test_back_to_back();
        test_reserved();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
